// File: rtl/ctl_useq_pkg.sv
// Shared encodings for the microprogram sequencer: states, uaddr mode codes,
// and field widths.
package ctl_useq_pkg;
  localparam int IR_W   = 16;
  localparam int MODE_W = 2;
  localparam int OP_DEF = 6;

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_IRQ   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [MODE_W-1:0] MODE_EXEC  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_FETCH = 2'b01;
  localparam logic [MODE_W-1:0] MODE_IRQ   = 2'b10;
  localparam logic [MODE_W-1:0] MODE_RST   = 2'b11;

  localparam logic [OP_DEF-1:0] HALT_OP = 6'h3F;
endpackage

// File: rtl/ctl_upc.sv
// Micro-step counter: hold beats clear beats increment; o_at_max flags the
// last step so the sequencer can force an end.
module ctl_upc #(
  parameter int UPC_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_hold,
  input  logic             i_clr,
  output logic [UPC_W-1:0] o_upc,
  output logic             o_at_max
);
  logic [UPC_W-1:0] r_upc;

  always_ff @(posedge i_clk) begin
    if (i_reset)      r_upc <= '0;
    else if (i_hold)  r_upc <= r_upc;
    else if (i_clr)   r_upc <= '0;
    else              r_upc <= r_upc + 1'b1;
  end

  assign o_upc    = r_upc;
  assign o_at_max = &r_upc;
endmodule

// File: rtl/ctl_useq.sv
// Microprogram sequencer: maps registered state/opcode/micro-step onto the
// microcode ROM address and walks reset, fetch, execute, interrupt and halt.
module ctl_useq
  import ctl_useq_pkg::*;
#(
  parameter int UPC_W   = 4,
  parameter int OP_LSB  = 10,
  parameter int UADDR_W = 12
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [IR_W-1:0]    i_ir,
  input  logic               i_uend,
  input  logic               i_wait,
  input  logic               i_irq_req,
  input  logic               i_irq_en,
  input  logic               i_halt_req,
  input  logic               i_step,
  output logic [UADDR_W-1:0] o_uaddr,
  output logic [UPC_W-1:0]   o_upc,
  output logic [2:0]         o_state,
  output logic               o_irq_ack,
  output logic               o_halted,
  output logic               o_uerr
);
  localparam int OP_W = IR_W - OP_LSB;

  state_t          r_state;
  logic [OP_W-1:0] r_op_q;
  logic            r_step_pend;
  logic            r_irq_ack;
  logic            r_uerr;
  logic            w_at_max;
  logic            w_end;
  logic            w_in_halt;
  logic            w_unused_ir;

  assign w_unused_ir = ^i_ir[OP_LSB-1:0];
  assign w_in_halt   = (r_state == ST_HALT);
  // HALT ignores uend and never reaches at-max, so no end is raised there.
  assign w_end       = !w_in_halt && (i_uend || w_at_max);

  ctl_upc #(.UPC_W(UPC_W)) u_upc (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_hold   (i_wait),
    .i_clr    (w_end || w_in_halt),
    .o_upc    (o_upc),
    .o_at_max (w_at_max)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_RST;
      r_op_q      <= '0;
      r_step_pend <= 1'b0;
      r_irq_ack   <= 1'b0;
      r_uerr      <= 1'b0;
    end else begin
      r_irq_ack <= 1'b0;
      if (!i_wait) begin
        if (w_end && w_at_max && !i_uend) r_uerr <= 1'b1;
        case (r_state)
          ST_RST:   if (w_end) r_state <= ST_FETCH;
          ST_FETCH: if (w_end) begin
            r_state <= ST_EXEC;
            r_op_q  <= i_ir[IR_W-1:OP_LSB];
          end
          ST_EXEC:  if (w_end) begin
            if (i_irq_req && i_irq_en) begin
              r_state   <= ST_IRQ;
              r_irq_ack <= 1'b1;
            end else if (i_halt_req || r_step_pend) begin
              r_state     <= ST_HALT;
              r_step_pend <= 1'b0;
            end else begin
              r_state <= ST_FETCH;
            end
          end
          ST_IRQ:   if (w_end) r_state <= ST_FETCH;
          ST_HALT:  if (i_step) begin
            r_state     <= ST_FETCH;
            r_step_pend <= 1'b1;
          end else if (!i_halt_req) begin
            r_state <= ST_FETCH;
          end
          default:  r_state <= ST_RST;
        endcase
      end
    end
  end

  always_comb begin
    o_uaddr = '0;
    case (r_state)
      ST_RST:   o_uaddr = {MODE_RST,   {OP_W{1'b0}}, o_upc};
      ST_FETCH: o_uaddr = {MODE_FETCH, {OP_W{1'b0}}, o_upc};
      ST_EXEC:  o_uaddr = {MODE_EXEC,  r_op_q,       o_upc};
      ST_IRQ:   o_uaddr = {MODE_IRQ,   {OP_W{1'b0}}, o_upc};
      ST_HALT:  o_uaddr = {MODE_IRQ,   OP_W'(HALT_OP), {UPC_W{1'b0}}};
      default:  o_uaddr = '0;
    endcase
  end

  assign o_state   = r_state;
  assign o_irq_ack = r_irq_ack;
  assign o_halted  = w_in_halt;
  assign o_uerr    = r_uerr;
endmodule

// File: tb/tb_ctl_useq.sv
// Directed bench for ctl_useq: reset, fetch/decode, wait, IRQ/halt,
// single-step and runaway guard, each with hand-computed expectations.
module tb_ctl_useq;
  import ctl_useq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ir = '0;
  logic        uend = 1'b0, wt = 1'b0, irq_req = 1'b0, irq_en = 1'b0;
  logic        halt_req = 1'b0, step = 1'b0;
  logic [11:0] uaddr;
  logic [3:0]  upc;
  logic [2:0]  state;
  logic        irq_ack, halted, uerr;
  int          total = 0;
  int          bad = 0;

  ctl_useq dut (
    .i_clk(clk), .i_reset(reset), .i_ir(ir), .i_uend(uend), .i_wait(wt),
    .i_irq_req(irq_req), .i_irq_en(irq_en), .i_halt_req(halt_req), .i_step(step),
    .o_uaddr(uaddr), .o_upc(upc), .o_state(state), .o_irq_ack(irq_ack),
    .o_halted(halted), .o_uerr(uerr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    total++; if (state !== 3'(ST_RST)) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", state, ST_RST); end
    total++; if (uaddr !== 12'hC00) begin bad++; $display("FAIL rst_uaddr got=%h exp=c00", uaddr); end
    total++; if (upc !== 4'd0) begin bad++; $display("FAIL rst_upc got=%0d exp=0", upc); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", halted); end
    total++; if (uerr !== 1'b0) begin bad++; $display("FAIL rst_uerr got=%b exp=0", uerr); end
    reset = 1'b0;
    tick(3);
    total++; if (uaddr !== 12'hC03) begin bad++; $display("FAIL freerun_uaddr got=%h exp=c03", uaddr); end
  endtask

  task automatic test_fetch_decode;
    reset = 1'b1; tick(1); reset = 1'b0;
    tick(2);
    uend = 1'b1; tick(1);
    total++; if (uaddr !== 12'h400) begin bad++; $display("FAIL rst_to_fetch got=%h exp=400", uaddr); end
    uend = 1'b0; tick(3);
    total++; if (uaddr !== 12'h403) begin bad++; $display("FAIL fetch_upc3 got=%h exp=403", uaddr); end
    ir = 16'hA7FF; uend = 1'b1; tick(1);
    total++; if (uaddr !== 12'h290) begin bad++; $display("FAIL decode got=%h exp=290", uaddr); end
    ir = 16'h0000; uend = 1'b0; tick(1);
    total++; if (uaddr !== 12'h291) begin bad++; $display("FAIL op_latched got=%h exp=291", uaddr); end
  endtask

  task automatic test_wait;
    uend = 1'b1; wt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      total++; if (uaddr !== 12'h291) begin bad++; $display("FAIL wait_hold%0d got=%h exp=291", i, uaddr); end
    end
    wt = 1'b0; tick(1);
    total++; if (uaddr !== 12'h400) begin bad++; $display("FAIL wait_release got=%h exp=400", uaddr); end
  endtask

  task automatic test_irq_halt;
    ir = 16'hA7FF; uend = 1'b1; tick(1);
    total++; if (uaddr !== 12'h290) begin bad++; $display("FAIL irq_exec got=%h exp=290", uaddr); end
    irq_req = 1'b1; irq_en = 1'b1; halt_req = 1'b1; tick(1);
    total++; if (uaddr !== 12'h800) begin bad++; $display("FAIL irq_uaddr got=%h exp=800", uaddr); end
    total++; if (irq_ack !== 1'b1) begin bad++; $display("FAIL irq_ack_hi got=%b exp=1", irq_ack); end
    irq_req = 1'b0; uend = 1'b0; tick(1);
    total++; if (irq_ack !== 1'b0) begin bad++; $display("FAIL irq_ack_lo got=%b exp=0", irq_ack); end
    total++; if (uaddr !== 12'h801) begin bad++; $display("FAIL irq_step got=%h exp=801", uaddr); end
    uend = 1'b1; tick(1);
    total++; if (state !== 3'(ST_FETCH)) begin bad++; $display("FAIL irq_to_fetch got=%0d exp=%0d", state, ST_FETCH); end
    tick(1);
    total++; if (uaddr !== 12'h290) begin bad++; $display("FAIL refetch got=%h exp=290", uaddr); end
    tick(1);
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halted got=%b exp=1", halted); end
    total++; if (uaddr !== 12'hBF0) begin bad++; $display("FAIL halt_uaddr got=%h exp=bf0", uaddr); end
    tick(1);
    total++; if (uaddr !== 12'hBF0) begin bad++; $display("FAIL halt_stay got=%h exp=bf0", uaddr); end
  endtask

  task automatic test_single_step;
    // plain step: halt_req dropped after leaving HALT, so only step_pend re-halts
    step = 1'b1; tick(1); step = 1'b0; halt_req = 1'b0;
    total++; if (uaddr !== 12'h400) begin bad++; $display("FAIL step_fetch got=%h exp=400", uaddr); end
    tick(1);
    total++; if (uaddr !== 12'h290) begin bad++; $display("FAIL step_exec got=%h exp=290", uaddr); end
    tick(1);
    total++; if (state !== 3'(ST_HALT)) begin bad++; $display("FAIL step_rehalt got=%0d exp=%0d", state, ST_HALT); end
    halt_req = 1'b1;
    step = 1'b1; tick(1); step = 1'b0; halt_req = 1'b0;
    tick(1);
    irq_req = 1'b1; tick(1);
    total++; if (state !== 3'(ST_IRQ) || irq_ack !== 1'b1) begin bad++; $display("FAIL step_irq state=%0d ack=%b exp=%0d/1", state, irq_ack, ST_IRQ); end
    irq_req = 1'b0; tick(1);
    total++; if (state !== 3'(ST_FETCH)) begin bad++; $display("FAIL step_irq_fetch got=%0d exp=%0d", state, ST_FETCH); end
    tick(1);
    total++; if (state !== 3'(ST_EXEC)) begin bad++; $display("FAIL step_irq_exec got=%0d exp=%0d", state, ST_EXEC); end
    tick(1);
    total++; if (state !== 3'(ST_HALT)) begin bad++; $display("FAIL step_pend_kept got=%0d exp=%0d", state, ST_HALT); end
    tick(1);
    total++; if (state !== 3'(ST_FETCH)) begin bad++; $display("FAIL step_pend_clr got=%0d exp=%0d", state, ST_FETCH); end
  endtask

  task automatic test_runaway;
    tick(1);
    total++; if (state !== 3'(ST_EXEC)) begin bad++; $display("FAIL run_exec got=%0d exp=%0d", state, ST_EXEC); end
    uend = 1'b0; tick(15);
    total++; if (uaddr !== 12'h29F || uerr !== 1'b0) begin bad++; $display("FAIL run_max uaddr=%h uerr=%b exp=29f/0", uaddr, uerr); end
    tick(1);
    total++; if (uaddr !== 12'h400 || uerr !== 1'b1) begin bad++; $display("FAIL run_guard uaddr=%h uerr=%b exp=400/1", uaddr, uerr); end
    tick(2);
    total++; if (uaddr !== 12'h402 || uerr !== 1'b1) begin bad++; $display("FAIL uerr_sticky uaddr=%h uerr=%b exp=402/1", uaddr, uerr); end
    reset = 1'b1; tick(1); reset = 1'b0;
    total++; if (uaddr !== 12'hC00 || uerr !== 1'b0 || upc !== 4'd0) begin bad++; $display("FAIL mid_reset uaddr=%h uerr=%b upc=%0d exp=c00/0/0", uaddr, uerr, upc); end
  endtask

  initial begin
    test_reset();
    test_fetch_decode();
    test_wait();
    test_irq_halt();
    test_single_step();
    test_runaway();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
